bus_responder: RTL

BUS_RESPONDER -- requirements
Module: bus_responder

---
 rtl/bus_responder.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/bus_responder.sv
// bus_responder: memory-mapped slave for a small processor.
//   Decodes ADDR[15:12] into RAM, LED register, display register, switch
//   input, free-running timer and a write-only HALT latch (0x4FFF).
//   Reads are registered (one cycle latency, read-before-write), and a
//   small FSM sequences the processor run request after reset.
//
// Ports
//   clock    - single clock, rising edge
//   reset    - asynchronous, active-high
//   ADDR     - word address from the processor
//   DOUT     - write data from the processor
//   W        - write enable
//   Done     - processor instruction-complete
//   SW       - asynchronous board switches
//   DIN      - registered read data to the processor
//   LEDR     - LED register
//   HEXDATA  - display register
//   run      - processor run request
//
// Run FSM
//   state | meaning
//   IDLE  | just out of reset, run low
//   WAIT  | settling delay before enabling the processor
//   RUN   | processor running, run high
//   HALT  | processor stopped until the next reset
module bus_responder #(
    parameter int RAM_AW = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] ADDR,
    input  logic [15:0] DOUT,
    input  logic        W,
    input  logic        Done,
    input  logic [9:0]  SW,
    output logic [15:0] DIN,
    output logic [9:0]  LEDR,
    output logic [15:0] HEXDATA,
    output logic        run
);

    typedef enum logic [1:0] {IDLE, WAIT, RUN, HALT} state_t;

    localparam logic [3:0]  REG_RAM  = 4'h0;
    localparam logic [3:0]  REG_LED  = 4'h1;
    localparam logic [3:0]  REG_HEX  = 4'h2;
    localparam logic [3:0]  REG_SW   = 4'h3;
    localparam logic [3:0]  REG_TMR  = 4'h4;
    localparam logic [15:0] HALT_ADR = 16'h4FFF;

    logic [15:0] mem [0:(2**RAM_AW)-1];

    logic [3:0]  region;
    logic        halt_addr;
    logic        sel_ram, sel_led, sel_hex, sel_tmr;
    logic [15:0] rdata;
    logic [9:0]  sw_meta, sw_sync;
    logic [15:0] timer;
    logic        halt_latch;

    state_t      state, state_nxt;
    logic [1:0]  wait_cnt, wait_cnt_nxt;

    assign region    = ADDR[15:12];
    assign halt_addr = (ADDR == HALT_ADR);
    assign sel_ram   = (region == REG_RAM);
    assign sel_led   = (region == REG_LED);
    assign sel_hex   = (region == REG_HEX);
    // The HALT latch lives inside the timer region but must not alias it.
    assign sel_tmr   = (region == REG_TMR) && !halt_addr;

    // RAM has no reset so that its contents survive a reset.
    always_ff @(posedge clock) begin
        if (W && sel_ram)
            mem[ADDR[RAM_AW-1:0]] <= DOUT;
    end

    // Read mux sees pre-edge values, which gives read-before-write.
    always_comb begin
        rdata = 16'h0000;
        unique case (region)
            REG_RAM: rdata = mem[ADDR[RAM_AW-1:0]];
            REG_LED: rdata = {6'b0, LEDR};
            REG_HEX: rdata = HEXDATA;
            REG_SW:  rdata = {6'b0, sw_sync};
            REG_TMR: rdata = sel_tmr ? timer : 16'h0000;
            default: rdata = 16'h0000;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            DIN        <= 16'h0000;
            LEDR       <= 10'h000;
            HEXDATA    <= 16'h0000;
            sw_meta    <= 10'h000;
            sw_sync    <= 10'h000;
            timer      <= 16'h0000;
            halt_latch <= 1'b0;
        end else begin
            DIN     <= rdata;
            sw_meta <= SW;
            sw_sync <= sw_meta;
            if (W && sel_led)
                LEDR <= DOUT[9:0];
            if (W && sel_hex)
                HEXDATA <= DOUT;
            // A write takes priority over the increment.
            timer <= (W && sel_tmr) ? DOUT : timer + 16'd1;
            if (W && halt_addr && DOUT[0])
                halt_latch <= 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            wait_cnt <= 2'd0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    // WAIT is entered with a count of 2 and leaves on terminal count, so
    // run rises on the fourth edge after reset is released.
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        run          = 1'b0;
        unique case (state)
            IDLE: begin
                state_nxt    = WAIT;
                wait_cnt_nxt = 2'd2;
            end
            WAIT: begin
                if (wait_cnt == 2'd0)
                    state_nxt = RUN;
                else
                    wait_cnt_nxt = wait_cnt - 2'd1;
            end
            RUN: begin
                run = 1'b1;
                if (Done && halt_latch)
                    state_nxt = HALT;
            end
            HALT: begin
                state_nxt = HALT;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule
